// File: rtl/clk_div_tick_sync_if.sv
// Signal bundle for clk_div_tick_sync: divided-clock inputs, tap control and tick/fault outputs.
// The master modport drives the inputs; the slave modport is the tick synchroniser.
interface clk_div_tick_sync_if #(
  parameter int unsigned NUM_DIV = 5,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_DIV-1:0] div_in;
  logic [2:0]         sel;
  logic               count_clr;
  logic               fault_clr;
  logic [NUM_DIV-1:0] tick_all;
  logic               tick_out;
  logic [CNT_W-1:0]   tick_count;
  logic               fault;

  modport master (
    output div_in, sel, count_clr, fault_clr,
    input  tick_all, tick_out, tick_count, fault
  );

  modport slave (
    input  div_in, sel, count_clr, fault_clr,
    output tick_all, tick_out, tick_count, fault
  );
endinterface

// File: rtl/clk_div_tick_sync.sv
// Synchronises ripple-divider taps into clk-domain tick strobes, counts ticks on a selected tap and
// flags a stalled tap with a watchdog. Define TICK_SAT_EN to make tick_count saturate instead of wrap.
module clk_div_tick_sync #(
  parameter int unsigned NUM_DIV     = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 128
) (
  input logic                clk,
  input logic                reset,
  clk_div_tick_sync_if.slave bus
);
  localparam int unsigned      MaskW    = $clog2(SYNC_STAGES + 2);
  localparam int unsigned      WdW      = $clog2(TIMEOUT);
  localparam logic [MaskW-1:0] MaskLoad = MaskW'(SYNC_STAGES + 1);
  localparam logic [WdW-1:0]   WdLast   = WdW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StSettle, StArmed, StFault} state_e;

  logic [NUM_DIV-1:0] sync_q [SYNC_STAGES];
  logic [NUM_DIV-1:0] prev_q;
  logic [NUM_DIV-1:0] tick_all_q;
  logic [2:0]         sel_q;
  logic [MaskW-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WdW-1:0]     wd_q, wd_d;
  state_e             state_q, state_d;
  logic               sel_chg, sel_valid, sel_tick, tick_out;

  assign sel_chg   = bus.sel != sel_q;
  assign sel_valid = 32'(sel_q) < NUM_DIV;

  always_comb begin
    sel_tick = 1'b0;
    for (int i = 0; i < NUM_DIV; i++) begin
      if (sel_q == 3'(i)) sel_tick = tick_all_q[i];
    end
  end

  // Mask hides the new tap until its edge pipeline holds only post-switch samples.
  assign tick_out = sel_valid && (mask_q == '0) && sel_tick;

  always_comb begin
    mask_d = mask_q;
    if (sel_chg)             mask_d = MaskLoad;
    else if (mask_q != '0)   mask_d = mask_q - MaskW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.count_clr) begin
      cnt_d = '0;
    end else if (tick_out) begin
`ifdef TICK_SAT_EN
      if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
`else
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q     <= '0;
      tick_all_q <= '0;
      sel_q      <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
    end else begin
      sync_q[0] <= bus.div_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q     <= sync_q[SYNC_STAGES-1];
      tick_all_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      sel_q      <= bus.sel;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StSettle;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Fault is raised after TIMEOUT consecutive armed cycles without a tick on the selected tap.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    unique case (state_q)
      StSettle: begin
        wd_d = '0;
        if (!sel_chg && sel_valid && (mask_q == '0)) state_d = StArmed;
      end
      StArmed: begin
        if (sel_chg) begin
          state_d = StSettle;
          wd_d    = '0;
        end else if (tick_out) begin
          wd_d = '0;
        end else if (wd_q == WdLast) begin
          wd_d    = '0;
          state_d = bus.fault_clr ? StSettle : StFault;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StFault: begin
        wd_d = '0;
        if (bus.fault_clr) state_d = StSettle;
      end
      default: begin
        state_d = StSettle;
        wd_d    = '0;
      end
    endcase
  end

  assign bus.tick_all   = tick_all_q;
  assign bus.tick_out   = tick_out;
  assign bus.tick_count = cnt_q;
  assign bus.fault      = (state_q == StFault);
endmodule
